adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 142 ++++++++++++++
 tb/tb_adder_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: N_REQ requesters share one two-stage adder pipeline.
// Round-robin arbitration feeds S1 (operands + id); S2 holds the sum and
// drives the response port directly, so responses come straight from flops.
module adder_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ*WIDTH-1:0]      req_operand1,
   input  logic [N_REQ*WIDTH-1:0]      req_operand2,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(N_REQ)-1:0]    rsp_id,
   output logic [WIDTH:0]              rsp_sum,
   output logic                        busy,
   output logic [15:0]                 done_count
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned SUM_W = WIDTH + 1;

   logic              s1_valid;
   logic [WIDTH-1:0]  s1_op1;
   logic [WIDTH-1:0]  s1_op2;
   logic [ID_W-1:0]   s1_id;
   logic              s2_valid;
   logic [WIDTH:0]    s2_sum;
   logic [ID_W-1:0]   s2_id;
   logic [ID_W-1:0]   last_granted;

   logic              deliver;
   logic              s2_load;
   logic              s1_free;
   logic              accept;
   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W:0]     cand;
   logic [WIDTH-1:0]  op1_sel;
   logic [WIDTH-1:0]  op2_sel;

   // Pipeline flow control: S2 frees on delivery, S1 frees when it moves on.
   assign deliver = s2_valid & rsp_ready;
   assign s2_load = ~s2_valid | deliver;
   assign s1_free = ~s1_valid | s2_load;
   assign accept  = |req_ready;

   // Round-robin search starting just after the last granted index.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_granted;
      cand      = '0;
      for (int unsigned off = 1; off <= N_REQ; off++) begin
         cand = {1'b0, last_granted} + (ID_W+1)'(off);
         if (cand >= (ID_W+1)'(N_REQ)) begin
            cand = cand - (ID_W+1)'(N_REQ);
         end
         if (!win_found && req_valid[cand[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[ID_W-1:0];
         end
      end
   end

   // Grant is one-hot on the winner only when S1 can take it and not in reset.
   always_comb begin
      req_ready = '0;
      if (win_found && s1_free && !reset) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // Operand mux keyed by the grant, so non-granted operands never leak in.
   always_comb begin
      op1_sel = '0;
      op2_sel = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (req_ready[i]) begin
            op1_sel = req_operand1[i*WIDTH +: WIDTH];
            op2_sel = req_operand2[i*WIDTH +: WIDTH];
         end
      end
   end

   // Stage 1: capture operands and id on accept, empty when advancing alone.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op1   <= '0;
         s1_op2   <= '0;
         s1_id    <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op1   <= op1_sel;
         s1_op2   <= op2_sel;
         s1_id    <= win_idx;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: full-width sum; holds while the response is stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_id    <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum <= SUM_W'(s1_op1) + SUM_W'(s1_op2);
            s2_id  <= s1_id;
         end
      end
   end

   // Arbitration pointer moves only on an accept; reset gives index 0 priority.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_granted <= ID_W'(N_REQ - 1);
      end else if (accept) begin
         last_granted <= win_idx;
      end
   end

   // Delivered-result counter, wraps naturally at 16 bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         done_count <= '0;
      end else if (deliver) begin
         done_count <= done_count + 16'd1;
      end
   end

   assign rsp_valid = s2_valid;
   assign rsp_sum   = s2_sum;
   assign rsp_id    = s2_id;
   assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed scenarios plus a randomized run,
// with a queue-based reference model checked every cycle on the falling edge.
module tb_adder_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] op1;
   logic [N*W-1:0] op2;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W:0]     rsp_sum;
   logic           busy;
   logic [15:0]    done_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { int id; int sum; int acc; } item_t;
   item_t q[$];
   int m_last = N - 1;
   int m_done = 0;
   int m_edge = 0;

   adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_operand1(op1), .req_operand2(op2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .busy(busy), .done_count(done_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: in-flight queue with accept edge numbers.
   // A result is visible once the edge after its accept has passed, and the
   // pipeline holds at most two operations.
   always @(negedge clock) begin : monitor
      int win;
      int exp_ready;
      bit exp_rv;
      bit deliver;
      bit can_acc;
      int a;
      int b;
      logic [N*W-1:0] sh1;
      logic [N*W-1:0] sh2;
      item_t it;
      if (reset) begin
         n_checks++;
         if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b busy=%b done=%0d, required all zero",
                     req_ready, rsp_valid, busy, done_count);
         end
         q.delete();
         m_last = N - 1;
         m_done = 0;
      end else begin
         m_edge++;
         exp_rv  = (q.size() > 0) && (q[0].acc <= m_edge - 2);
         deliver = exp_rv && rsp_ready;
         can_acc = (q.size() - (deliver ? 1 : 0)) < 2;
         win = -1;
         for (int k = 1; k <= N; k++) begin
            if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
         end
         exp_ready = (can_acc && win >= 0) ? (1 << win) : 0;

         n_checks++;
         if (req_ready !== N'(exp_ready)) begin
            n_fail++;
            $display("FAIL model_req_ready: got %b expected %b", req_ready, N'(exp_ready));
         end
         n_checks++;
         if (rsp_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL model_rsp_valid: got %b expected %b", rsp_valid, exp_rv);
         end
         n_checks++;
         if (busy !== (q.size() > 0)) begin
            n_fail++;
            $display("FAIL model_busy: got %b expected %b", busy, (q.size() > 0));
         end
         n_checks++;
         if (done_count !== 16'(m_done)) begin
            n_fail++;
            $display("FAIL model_done_count: got %0d expected %0d", done_count, 16'(m_done));
         end
         if (exp_rv) begin
            n_checks++;
            if (rsp_id !== 2'(q[0].id) || rsp_sum !== 9'(q[0].sum)) begin
               n_fail++;
               $display("FAIL model_result: got id=%0d sum=%0d expected id=%0d sum=%0d",
                        rsp_id, rsp_sum, q[0].id, q[0].sum);
            end
         end

         if (deliver) begin
            void'(q.pop_front());
            m_done++;
         end
         if (exp_ready != 0) begin
            sh1 = op1 >> (win * W);
            sh2 = op2 >> (win * W);
            a = int'(sh1[W-1:0]);
            b = int'(sh2[W-1:0]);
            it.id  = win;
            it.sum = a + b;
            it.acc = m_edge;
            q.push_back(it);
            m_last = win;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      req_valid = '1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || done_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_hold: ready=%b rsp_valid=%b done=%0d, required 0000/0/0",
                  req_ready, rsp_valid, done_count);
      end
      req_valid = '0;
      reset = 1'b0;
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      op1 = '0; op2 = '0;
      op1[7:0] = 8'd2;
      op2[7:0] = 8'd3;
      req_valid = 4'b0001;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("FAIL single_grant: got %b expected 0001", req_ready);
      end
      tick();
      req_valid = '0;
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_s1: rsp_valid=%b busy=%b expected 0/1", rsp_valid, busy);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 9'd5 || rsp_id !== 2'd0) begin
         n_fail++;
         $display("FAIL single_result: valid=%b sum=%0d id=%0d expected 1/5/0", rsp_valid, rsp_sum, rsp_id);
      end
      tick();
      n_checks++;
      if (done_count !== 16'd1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%0d valid=%b busy=%b expected 1/0/0", done_count, rsp_valid, busy);
      end
   endtask

   task automatic test_carry();
      op1[23:16] = 8'd255;
      op2[23:16] = 8'd255;
      req_valid = 4'b0100;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++;
         $display("FAIL carry_grant: got %b expected 0100", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 9'h1FE || rsp_id !== 2'd2) begin
         n_fail++;
         $display("FAIL carry_result: valid=%b sum=%0h id=%0d expected 1/1fe/2", rsp_valid, rsp_sum, rsp_id);
      end
      tick();
      n_checks++;
      if (done_count !== 16'd2) begin
         n_fail++;
         $display("FAIL carry_done: got %0d expected 2", done_count);
      end
   endtask

   task automatic test_round_robin();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int c = 0; c < 12; c++) begin
         op1 = {$urandom, $urandom};
         op2 = {$urandom, $urandom};
         #1;
         n_checks++;
         if (req_ready !== 4'(1 << (c % 4))) begin
            n_fail++;
            $display("FAIL rr_grant_%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4)));
         end
         if (c >= 2) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4)) begin
               n_fail++;
               $display("FAIL rr_stream_%0d: valid=%b id=%0d expected 1/%0d", c, rsp_valid, rsp_id, (c - 2) % 4);
            end
         end
         tick();
      end
      drain();
   endtask

   task automatic test_backpressure();
      int exp0;
      int exp1;
      op1 = {$urandom, $urandom};
      op2 = {$urandom, $urandom};
      exp0 = int'(op1[7:0]) + int'(op2[7:0]);
      exp1 = int'(op1[15:8]) + int'(op2[15:8]);
      rsp_ready = 1'b0;
      req_valid = '1;
      tick();
      tick();
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
             rsp_sum !== 9'(exp0) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: ready=%b valid=%b id=%0d sum=%0d busy=%b expected 0000/1/0/%0d/1",
                     c, req_ready, rsp_valid, rsp_id, rsp_sum, busy, exp0);
         end
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'(exp1)) begin
         n_fail++;
         $display("FAIL bp_second: valid=%b id=%0d sum=%0d expected 1/1/%0d", rsp_valid, rsp_id, rsp_sum, exp1);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_empty: valid=%b expected 0", rsp_valid);
      end
      drain();
   endtask

   task automatic test_fairness();
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++;
         $display("FAIL fair_first: got %b expected 1000", req_ready);
      end
      tick();
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL fair_second: got %b expected 0010", req_ready);
      end
      tick();
      drain();
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b0;
      req_valid = '1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_sum !== 9'd0 || rsp_id !== 2'd0 || busy !== 1'b0 ||
          done_count !== 16'd0 || req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL midreset_clear: valid=%b sum=%0d id=%0d busy=%b done=%0d ready=%b expected all zero",
                  rsp_valid, rsp_sum, rsp_id, busy, done_count, req_ready);
      end
      tick();
      reset = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b0110;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL midreset_grant: got %b expected 0010", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
         n_fail++;
         $display("FAIL midreset_next: valid=%b id=%0d expected 1/1", rsp_valid, rsp_id);
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         op1 = {$urandom, $urandom};
         op2 = {$urandom, $urandom};
         tick();
      end
      drain();
      n_checks++;
      if (busy !== 1'b0 || done_count !== 16'(m_done)) begin
         n_fail++;
         $display("FAIL random_final: busy=%b done=%0d expected 0/%0d", busy, done_count, 16'(m_done));
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      op1 = '0;
      op2 = '0;
      test_reset();
      test_single();
      test_carry();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
